scan_loader: RTL and testbench

// - Host-side master for the pattern-buffer serial scan interface (sin/sout/ssel/saddr).
// - Takes a byte stream from the host and shifts one full buffer image into the

---
 rtl/pat_scan_pkg.sv | 30 +++
 rtl/scan_loader_if.sv | 53 +++++
 rtl/scan_shifter.sv | 46 ++++
 rtl/scan_loader.sv | 131 +++++++++++++
 tb/tb_scan_loader.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pat_scan_pkg.sv
// Shared constants, state encoding and helpers for the pattern-buffer scan path.
// Pure declarations: no latency.
// No backpressure of its own.
package pat_scan_pkg;

    // Pattern buffer geometry: 22 bytes of 8 bits, 8 buffers.
    localparam int SCAN_BYTES = 22;
    localparam int SCAN_WIDTH = 8;
    localparam int SCAN_BUFS  = 8;

    // Derived widths used by the interfaces and the loader.
    localparam int SCAN_AW    = $clog2(SCAN_BUFS);
    localparam int SCAN_BCW   = $clog2(SCAN_BYTES);
    localparam int SCAN_CHAIN = SCAN_BYTES * SCAN_WIDTH;

    // Loader transfer phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } scan_state_t;

    // True when a byte count refers to the final byte of an image of nbytes.
    function automatic logic is_last_byte(input logic [SCAN_BCW-1:0] cnt,
                                          input int                  nbytes);
        return cnt == SCAN_BCW'(nbytes - 1);
    endfunction

endpackage

// File: rtl/scan_loader_if.sv
// Host-side byte streams and the serial scan bus of the pattern buffers.
// Wires only: no latency.
// Host streams use valid/ready; the scan bus has no flow control.

// Host/config port: transfer control plus write and readback byte streams.
// master = host, slave = scan_loader.
interface scan_host_if import pat_scan_pkg::*; #(
    parameter int BW = SCAN_WIDTH,
    parameter int AW = SCAN_AW
) ();
    logic          start;
    logic [AW-1:0] addr;
    logic          abort;
    logic          busy;
    logic          done;
    logic [BW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [BW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;

    modport master (
        output start, addr, abort, wr_data, wr_valid, rd_ready,
        input  busy, done, wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  start, addr, abort, wr_data, wr_valid, rd_ready,
        output busy, done, wr_ready, rd_data, rd_valid
    );
endinterface

// Serial scan bus into the buffers block.
// master = scan_loader (sole driver), slave = buffers.
interface scan_chain_if import pat_scan_pkg::*; #(
    parameter int AW = SCAN_AW
) ();
    logic          sin;
    logic          ssel;
    logic [AW-1:0] saddr;
    logic          sout;

    modport master (
        output sin, ssel, saddr,
        input  sout
    );

    modport slave (
        input  sin, ssel, saddr,
        output sout
    );
endinterface

// File: rtl/scan_shifter.sv
// One-byte serialiser/deserialiser: PISO towards sin, SIPO from sout, common enable.
// One bit per enabled clk; last_bit flags the final shift of a byte.
// No backpressure: the controller decides when to load and when to shift.
module scan_shifter #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [BW-1:0] din,
    input  logic          shift,
    input  logic          sout,
    output logic          sin,
    output logic [BW-1:0] cap_nxt,
    output logic          last_bit
);

    localparam int CW = (BW > 1) ? $clog2(BW) : 1;

    logic [BW-1:0] piso_q;
    logic [BW-1:0] sipo_q;
    logic [CW-1:0] bit_cnt_q;

    // MSB leaves first; the capture side fills from the LSB so the first
    // bit out of the chain ends up as the MSB of the readback byte.
    assign sin      = piso_q[BW-1];
    assign cap_nxt  = {sipo_q[BW-2:0], sout};
    assign last_bit = shift && (bit_cnt_q == CW'(BW - 1));

    // Load a fresh byte, or advance both registers and the bit counter together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            piso_q    <= '0;
            sipo_q    <= '0;
            bit_cnt_q <= '0;
        end else if (load) begin
            piso_q    <= din;
            bit_cnt_q <= '0;
        end else if (shift) begin
            piso_q    <= {piso_q[BW-2:0], 1'b0};
            sipo_q    <= cap_nxt;
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/scan_loader.sv
// Shifts a host byte stream into one pattern buffer and returns the old image as bytes.
// Byte accepted at N -> ssel N+1..N+8 -> rd_valid at N+9; 10 cycles/byte with rd_ready high.
// A pending readback byte holds wr_ready low, so the chain freezes until the host drains it.
module scan_loader import pat_scan_pkg::*; #(
    parameter int buffer_size  = SCAN_BYTES,
    parameter int buffer_width = SCAN_WIDTH,
    parameter int no_bufs      = SCAN_BUFS
) (
    input logic          clk,
    input logic          rst,
    scan_host_if.slave   host,
    scan_chain_if.master chain
);

    localparam int BW  = buffer_width;
    localparam int AW  = $clog2(no_bufs);
    localparam int BCW = $clog2(buffer_size);

    scan_state_t    state_q;
    logic [BCW-1:0] byte_cnt_q;
    logic [AW-1:0]  saddr_q;
    logic [BW-1:0]  rd_data_q;
    logic           busy_q;
    logic           done_q;
    logic           rd_valid_q;
    logic           ssel_q;

    logic           wr_ready_w;
    logic           wr_hs;
    logic           rd_hs;
    logic           abort_now;
    logic           load_en;
    logic           sin_w;
    logic           last_bit;
    logic [BW-1:0]  cap_nxt;

    // Only wr_ready is combinational; every other output comes straight from a flop.
    assign wr_ready_w = (state_q == LOAD) && !rd_valid_q;
    assign wr_hs      = host.wr_valid && wr_ready_w;
    assign rd_hs      = rd_valid_q && host.rd_ready;
    assign abort_now  = host.abort && (state_q != IDLE);
    // An abort wins over a byte offered in the same cycle, so nothing gets loaded.
    assign load_en    = wr_hs && !abort_now;

    scan_shifter #(
        .BW (BW)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_en),
        .din      (host.wr_data),
        .shift    (ssel_q),
        .sout     (chain.sout),
        .sin      (sin_w),
        .cap_nxt  (cap_nxt),
        .last_bit (last_bit)
    );

    // Transfer FSM: owns ssel, the byte counter and the host status/readback flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            saddr_q    <= '0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            ssel_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_now) begin
                // The chain keeps whatever was shifted so far; nothing is repaired.
                state_q    <= IDLE;
                ssel_q     <= 1'b0;
                rd_valid_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                // rd_valid is never set in the same cycle it can be consumed,
                // because it is always low while shifting.
                if (rd_hs) begin
                    rd_valid_q <= 1'b0;
                end
                case (state_q)
                    IDLE: begin
                        if (host.start) begin
                            state_q    <= LOAD;
                            saddr_q    <= host.addr;
                            byte_cnt_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (wr_hs) begin
                            state_q <= SHIFT;
                            ssel_q  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (last_bit) begin
                            ssel_q     <= 1'b0;
                            rd_data_q  <= cap_nxt;
                            rd_valid_q <= 1'b1;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            state_q    <= is_last_byte(byte_cnt_q, buffer_size) ? DRAIN : LOAD;
                        end
                    end
                    DRAIN: begin
                        if (rd_hs) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign host.wr_ready = wr_ready_w;
    assign host.rd_data  = rd_data_q;
    assign host.rd_valid = rd_valid_q;

    assign chain.sin     = sin_w;
    assign chain.ssel    = ssel_q;
    assign chain.saddr   = saddr_q;

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: behavioural scan chains plus a per-buffer image model.
// Host side driven cycle by cycle, outputs sampled 1 time unit after each rising edge.
// Random valid/ready gaps, long rd_ready stalls, abort and reset in mid-byte.
module tb_scan_loader;
    import pat_scan_pkg::*;

    localparam int NB = SCAN_BYTES;
    localparam int BW = SCAN_WIDTH;
    localparam int CL = SCAN_CHAIN;
    localparam int AW = SCAN_AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_host_if  host_if ();
    scan_chain_if chain_if ();

    scan_loader dut (
        .clk   (clk),
        .rst   (rst),
        .host  (host_if.slave),
        .chain (chain_if.master)
    );

    // Buffers block: one CL-bit chain per buffer, oldest bit presented on sout.
    logic [CL-1:0] chain_m [SCAN_BUFS] = '{default: {NB{8'hA5}}};
    assign chain_if.sout = chain_m[chain_if.saddr][CL-1];

    int unsigned   cyc        = 0;
    int unsigned   ssel_total = 0;
    int unsigned   saddr_bad  = 0;
    logic [AW-1:0] saddr_exp  = '0;
    bit            sin_log [$];

    // Chain shifts and bus observation on every edge that ssel is high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (chain_if.ssel) begin
            chain_m[chain_if.saddr] <= {chain_m[chain_if.saddr][CL-2:0], chain_if.sin};
            ssel_total <= ssel_total + 1;
            sin_log.push_back(chain_if.sin);
            if (chain_if.saddr !== saddr_exp) saddr_bad <= saddr_bad + 1;
        end
    end

    // Reference model: the image each buffer holds, byte 0 first.
    logic [7:0] img    [SCAN_BUFS][NB];
    bit         img_ok [SCAN_BUFS];
    logic [7:0] wb [NB];
    logic [7:0] rb [$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < NB; k++) wb[k] = 8'($urandom);
    endtask

    task automatic run_xfer(input int b, input bit rnd, input bit stall, input bit poke_start);
        int          wi = 0;
        int          hs_r = 0;
        int          budget = 0;
        int          stall_left = 0;
        int          stall_bad = 0;
        int          done_cnt = 0;
        int          sin_bad = 0;
        int          rv_cyc = -1;
        int unsigned ssel0;
        int unsigned sbad0;
        int          sin0;
        int          wcyc [$];
        bit          stalled = 0;
        logic        w_hs;
        logic        r_hs;
        rb.delete();
        ssel0 = ssel_total;
        sbad0 = saddr_bad;
        sin0  = sin_log.size();
        saddr_exp = AW'(b);
        host_if.addr  = AW'(b);
        host_if.start = 1'b1;
        @(posedge clk); #1;
        host_if.start = 1'b0;
        check("busy_after_start", 32'(host_if.busy), 1);
        while (budget < 3000) begin
            host_if.wr_valid = (wi < NB) ? (!rnd || $urandom_range(0, 3) != 0) : rnd;
            host_if.wr_data  = (wi < NB) ? wb[wi] : 8'hEE;
            if (stall && !stalled && host_if.rd_valid) begin
                stalled    = 1;
                stall_left = 30;
            end
            if (stall_left > 0) begin
                host_if.rd_ready = 1'b0;
                stall_left--;
                if (host_if.wr_ready || chain_if.ssel) stall_bad++;
            end else begin
                host_if.rd_ready = !rnd || $urandom_range(0, 2) != 0;
            end
            host_if.start = poke_start && (wi == 5);
            host_if.addr  = (poke_start && wi == 5) ? AW'(b ^ 1) : AW'(b);
            w_hs = host_if.wr_valid && host_if.wr_ready;
            r_hs = host_if.rd_valid && host_if.rd_ready;
            if (r_hs) rb.push_back(host_if.rd_data);
            if (w_hs) wcyc.push_back(int'(cyc));
            if (host_if.rd_valid && rv_cyc < 0) rv_cyc = int'(cyc);
            @(posedge clk); #1;
            budget++;
            if (w_hs) wi++;
            if (r_hs) hs_r++;
            if (host_if.done) done_cnt++;
            if (r_hs && hs_r == NB) begin
                check("done_after_last_rd", 32'(host_if.done), 1);
                check("busy_clear_at_done", 32'(host_if.busy), 0);
                break;
            end
        end
        host_if.start    = 1'b0;
        host_if.addr     = AW'(b);
        host_if.wr_valid = 1'b0;
        host_if.rd_ready = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", 32'(host_if.done), 0);
        check("done_count", done_cnt, 1);
        check("wr_handshakes", wi, NB);
        check("rd_handshakes", hs_r, NB);
        check("ssel_cycles", ssel_total - ssel0, CL);
        check("saddr_stable", saddr_bad - sbad0, 0);
        check("saddr_final", 32'(chain_if.saddr), b);
        for (int k = 0; k < NB; k++)
            for (int j = 0; j < BW; j++)
                if (sin0 + k * BW + j >= sin_log.size() ||
                    sin_log[sin0 + k * BW + j] !== wb[k][BW-1-j]) sin_bad++;
        check("sin_msb_first", sin_bad, 0);
        if (stall) begin
            check("stall_entered", 32'(stalled), 1);
            check("stall_frozen", stall_bad, 0);
        end
        if (!rnd && !stall && wcyc.size() > 1) begin
            check("lat_wr_to_rdvalid", rv_cyc - wcyc[0], 9);
            check("byte_period", wcyc[1] - wcyc[0], 10);
        end
        if (img_ok[b]) begin
            for (int k = 0; k < NB; k++)
                check($sformatf("readback_b%0d_k%0d", b, k),
                      (k < rb.size()) ? 32'(rb[k]) : 32'hDEAD, 32'(img[b][k]));
        end
        for (int k = 0; k < NB; k++) img[b][k] = wb[k];
        img_ok[b] = 1;
    endtask

    task automatic run_partial(input int b, input int nbyte, input int nbit, input bit use_rst);
        int   wi = 0;
        int   guard = 0;
        logic w_hs;
        saddr_exp = AW'(b);
        host_if.addr     = AW'(b);
        host_if.start    = 1'b1;
        host_if.rd_ready = 1'b1;
        @(posedge clk); #1;
        host_if.start = 1'b0;
        while (wi <= nbyte && guard < 1000) begin
            host_if.wr_valid = 1'b1;
            host_if.wr_data  = 8'($urandom);
            w_hs = host_if.wr_valid && host_if.wr_ready;
            @(posedge clk); #1;
            guard++;
            if (w_hs) wi++;
        end
        host_if.wr_valid = 1'b0;
        check("partial_bytes", wi, nbyte + 1);
        repeat (nbit) @(posedge clk);
        #1;
        check("partial_mid_byte_ssel", 32'(chain_if.ssel), 1);
        if (use_rst) begin
            #2 rst = 1'b1;
            #1;
            check("rst_async_ssel", 32'(chain_if.ssel), 0);
            check("rst_async_rd_valid", 32'(host_if.rd_valid), 0);
            check("rst_async_busy", 32'(host_if.busy), 0);
            check("rst_async_saddr", 32'(chain_if.saddr), 0);
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            host_if.abort = 1'b1;
            @(posedge clk); #1;
            host_if.abort = 1'b0;
            check("abort_busy", 32'(host_if.busy), 0);
            check("abort_ssel", 32'(chain_if.ssel), 0);
            check("abort_rd_valid", 32'(host_if.rd_valid), 0);
            check("abort_wr_ready", 32'(host_if.wr_ready), 0);
        end
        host_if.rd_ready = 1'b0;
        repeat (3) begin
            check("no_done_after_cut", 32'(host_if.done), 0);
            @(posedge clk); #1;
        end
        img_ok[b] = 0;
    endtask

    initial begin
        for (int i = 0; i < SCAN_BUFS; i++) begin
            img_ok[i] = 1;
            for (int k = 0; k < NB; k++) img[i][k] = 8'hA5;
        end
        host_if.start    = 1'b0;
        host_if.addr     = '0;
        host_if.abort    = 1'b0;
        host_if.wr_data  = '0;
        host_if.wr_valid = 1'b0;
        host_if.rd_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(host_if.busy), 0);
        check("rst_done", 32'(host_if.done), 0);
        check("rst_wr_ready", 32'(host_if.wr_ready), 0);
        check("rst_rd_valid", 32'(host_if.rd_valid), 0);
        check("rst_rd_data", 32'(host_if.rd_data), 0);
        check("rst_ssel", 32'(chain_if.ssel), 0);
        check("rst_sin", 32'(chain_if.sin), 0);
        check("rst_saddr", 32'(chain_if.saddr), 0);
        rst = 1'b0;

        // Data offered while idle must not be taken.
        host_if.wr_valid = 1'b1;
        host_if.wr_data  = 8'h5A;
        host_if.rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_wr_ready", 32'(host_if.wr_ready), 0);
        check("idle_ssel", 32'(chain_if.ssel), 0);
        check("idle_busy", 32'(host_if.busy), 0);
        host_if.wr_valid = 1'b0;
        host_if.rd_ready = 1'b0;

        // Ramp image into a fresh buffer, then overwrite it and read the ramp back.
        for (int k = 0; k < NB; k++) wb[k] = 8'(k);
        run_xfer(3, 0, 0, 0);
        for (int k = 0; k < NB; k++) wb[k] = 8'hFF;
        run_xfer(3, 0, 0, 0);

        // Random data with gaps and a long readback stall after byte 0.
        fill_random();
        wb[0] = 8'h81;
        run_xfer(3, 1, 1, 0);

        // Random gaps plus a start pulse with another addr while busy.
        fill_random();
        run_xfer(5, 1, 0, 1);

        // Abort in LOAD while a byte is offered: abort wins, nothing shifts.
        host_if.addr  = AW'(4);
        saddr_exp     = AW'(4);
        host_if.start = 1'b1;
        @(posedge clk); #1;
        host_if.start    = 1'b0;
        host_if.wr_valid = 1'b1;
        host_if.wr_data  = 8'h3C;
        host_if.abort    = 1'b1;
        check("load_abort_wr_ready", 32'(host_if.wr_ready), 1);
        @(posedge clk); #1;
        host_if.abort    = 1'b0;
        host_if.wr_valid = 1'b0;
        check("load_abort_ssel", 32'(chain_if.ssel), 0);
        check("load_abort_busy", 32'(host_if.busy), 0);

        // Abort in byte 10, bit 4; then refill that buffer twice.
        run_partial(6, 10, 4, 0);
        fill_random();
        run_xfer(6, 1, 0, 0);
        fill_random();
        run_xfer(6, 1, 0, 0);

        // Reset in byte 5, bit 3; the next transfer must behave normally.
        run_partial(7, 5, 3, 1);
        fill_random();
        run_xfer(2, 0, 0, 0);
        run_xfer(4, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
